// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults and helpers for the VGA timing pipe.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    // Right-aligned width-bit value repeated MSB-first to fill 4 bits.
    function automatic logic [3:0] expand4(input logic [3:0] value, input int width);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < 4; i++) begin
            r[2'(3 - i)] = value[2'(width - 1 - (i % width))];
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register, DEPTH cycles of latency (DEPTH=0 is a wire).
// Free-running, no backpressure; async reset loads RESET_VAL into every stage.
module vga_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             vgaclk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = vgaclk ^ rst_n;
        assign q_o = d_i;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge vgaclk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA counters, sync/de decode and colour output stage; sync, de and colour reach
// the pins LAT+1 cycles after their hc_out/vc_out. Free-running, no backpressure.
module vga_timing_pipe
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   RW       = 3,
    parameter int   GW       = 3,
    parameter int   BW       = 2,
    parameter int   LAT      = 1
) (
    input  logic          vgaclk,
    input  logic          rst_n,
    input  logic          blank_req,
    input  logic [RW-1:0] input_red,
    input  logic [GW-1:0] input_green,
    input  logic [BW-1:0] input_blue,
    output logic [9:0]    hc_out,
    output logic [9:0]    vc_out,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_N = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_N = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (RW < 1 || RW > 4 || GW < 1 || GW > 4 || BW < 1 || BW > 4) begin : g_bad_width
        $error("vga_timing_pipe: colour widths must be 1..4");
    end
    if (LAT < 0 || LAT > 4) begin : g_bad_lat
        $error("vga_timing_pipe: LAT must be 0..4");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_pipe: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] hc_q, hc_d, vc_q, vc_d;

    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end
    end

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= 10'd0;
            vc_q <= 10'd0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign hc_out      = hc_q;
    assign vc_out      = vc_q;
    assign line_start  = (hc_q == 10'd0);
    assign frame_start = line_start && (vc_q == 10'd0);

    logic       h_act, v_act, hs_raw, vs_raw;
    logic [2:0] flg_raw, flg_dly;

    assign h_act   = {1'b0, hc_q} < H_ACT_N;
    assign v_act   = {1'b0, vc_q} < V_ACT_N;
    assign hs_raw  = ({1'b0, hc_q} >= HS_BEG) && ({1'b0, hc_q} < HS_END);
    assign vs_raw  = ({1'b0, vc_q} >= VS_BEG) && ({1'b0, vc_q} < VS_END);
    assign flg_raw = {h_act && v_act, hs_raw, vs_raw};

    // Flags wait LAT cycles so they meet the colour the graphics module returns.
    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (LAT),
        .RESET_VAL (3'b000)
    ) u_flag_dly (
        .vgaclk (vgaclk),
        .rst_n  (rst_n),
        .d_i    (flg_raw),
        .q_o    (flg_dly)
    );

    logic       show;
    logic       de_q, hsync_q, vsync_q;
    logic [3:0] red_q, green_q, blue_q;

    assign show = flg_dly[2] && !blank_req;

    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            red_q   <= 4'h0;
            green_q <= 4'h0;
            blue_q  <= 4'h0;
        end else begin
            de_q    <= flg_dly[2];
            hsync_q <= flg_dly[1] ? HS_POL : ~HS_POL;
            vsync_q <= flg_dly[0] ? VS_POL : ~VS_POL;
            red_q   <= show ? expand4(4'(input_red), RW)   : 4'h0;
            green_q <= show ? expand4(4'(input_green), GW) : 4'h0;
            blue_q  <= show ? expand4(4'(input_blue), BW)  : 4'h0;
        end
    end

    assign de    = de_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Five timing pipes (defaults, LAT 0/2/4, small custom timing) checked every cycle
// against an arithmetic model of coordinates, delays and colour expansion.
module tb_vga_timing_pipe;

    localparam int NI = 5;
    localparam int P_HA   [NI] = '{640, 640, 640, 640, 8};
    localparam int P_HF   [NI] = '{16, 16, 16, 16, 2};
    localparam int P_HS   [NI] = '{96, 96, 96, 96, 3};
    localparam int P_HB   [NI] = '{48, 48, 48, 48, 3};
    localparam int P_VA   [NI] = '{480, 480, 480, 480, 4};
    localparam int P_VF   [NI] = '{10, 10, 10, 10, 1};
    localparam int P_VS   [NI] = '{2, 2, 2, 2, 2};
    localparam int P_VB   [NI] = '{33, 33, 33, 33, 1};
    localparam int P_HPOL [NI] = '{0, 0, 0, 0, 1};
    localparam int P_VPOL [NI] = '{0, 0, 0, 0, 0};
    localparam int P_RW   [NI] = '{3, 3, 3, 3, 1};
    localparam int P_GW   [NI] = '{3, 3, 3, 3, 2};
    localparam int P_BW   [NI] = '{2, 2, 2, 2, 4};
    localparam int P_LAT  [NI] = '{1, 0, 2, 4, 1};

    typedef struct packed {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       ls;
        logic       fs;
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } obs_t;

    logic          clk;
    logic          rst_n;
    logic [NI-1:0] blk;
    logic [3:0]    ir [NI];
    logic [3:0]    ig [NI];
    logic [3:0]    ib [NI];
    wire  [9:0]    hc_w [NI];
    wire  [9:0]    vc_w [NI];
    wire  [NI-1:0] ls_w, fs_w, hs_w, vs_w, de_w;
    wire  [3:0]    r_w [NI];
    wire  [3:0]    g_w [NI];
    wire  [3:0]    b_w [NI];

    int nvec = 0;
    int nmis = 0;
    int def_hs = 0, def_de = 0, sm_fs = 0, sm_hh = 0, sm_vl = 0;

    initial clk = 1'b0;
    always #20 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        vga_timing_pipe #(
            .H_ACTIVE (P_HA[gi]), .H_FP (P_HF[gi]), .H_SYNC (P_HS[gi]), .H_BP (P_HB[gi]),
            .V_ACTIVE (P_VA[gi]), .V_FP (P_VF[gi]), .V_SYNC (P_VS[gi]), .V_BP (P_VB[gi]),
            .HS_POL   (P_HPOL[gi] != 0), .VS_POL (P_VPOL[gi] != 0),
            .RW (P_RW[gi]), .GW (P_GW[gi]), .BW (P_BW[gi]), .LAT (P_LAT[gi])
        ) u_dut (
            .vgaclk      (clk),
            .rst_n       (rst_n),
            .blank_req   (blk[gi]),
            .input_red   (ir[gi][P_RW[gi]-1:0]),
            .input_green (ig[gi][P_GW[gi]-1:0]),
            .input_blue  (ib[gi][P_BW[gi]-1:0]),
            .hc_out      (hc_w[gi]),
            .vc_out      (vc_w[gi]),
            .line_start  (ls_w[gi]),
            .frame_start (fs_w[gi]),
            .hsync       (hs_w[gi]),
            .vsync       (vs_w[gi]),
            .de          (de_w[gi]),
            .red         (r_w[gi]),
            .green       (g_w[gi]),
            .blue        (b_w[gi])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp4(input logic [3:0] v, input int w);
        case (w)
            1:       return v[0] ? 4'hF : 4'h0;
            2:       return 4'(v[1:0]) * 4'd5;
            3:       return {v[2:0], v[2]};
            default: return v;
        endcase
    endfunction

    function automatic logic [11:0] col_of(input int i, input int x, input int y);
        if (i == 0) return {4'd7, 4'd7, 4'd3};
        if (i == 4) return {4'd1, 4'd2, 4'd6};
        return {4'(x % 8), 4'(y % 8), 4'(x % 4)};
    endfunction

    function automatic logic blank_of(input int i, input int x, input int y);
        return (i == 0) && (x == 10) && (y == 0);
    endfunction

    function automatic obs_t model(input int i, input int n);
        obs_t o;
        int ht, vt, k, x, y;
        logic [11:0] c;
        ht   = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt   = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        o    = '0;
        o.hc = 10'(n % ht);
        o.vc = 10'((n / ht) % vt);
        o.ls = (n % ht) == 0;
        o.fs = o.ls && (o.vc == 10'd0);
        o.hs = (P_HPOL[i] == 0);
        o.vs = (P_VPOL[i] == 0);
        k    = n - P_LAT[i] - 1;
        if (k >= 0) begin
            x = k % ht;
            y = (k / ht) % vt;
            o.de = (x < P_HA[i]) && (y < P_VA[i]);
            if (x >= P_HA[i] + P_HF[i] && x < P_HA[i] + P_HF[i] + P_HS[i]) o.hs = (P_HPOL[i] != 0);
            if (y >= P_VA[i] + P_VF[i] && y < P_VA[i] + P_VF[i] + P_VS[i]) o.vs = (P_VPOL[i] != 0);
            if (o.de && !blank_of(i, x, y)) begin
                c   = col_of(i, x, y);
                o.r = exp4(c[11:8], P_RW[i]);
                o.g = exp4(c[7:4], P_GW[i]);
                o.b = exp4(c[3:0], P_BW[i]);
            end
        end
        return o;
    endfunction

    function automatic obs_t obs(input int i);
        return '{hc_w[i], vc_w[i], ls_w[i], fs_w[i], hs_w[i], vs_w[i], de_w[i], r_w[i], g_w[i], b_w[i]};
    endfunction

    // Inputs for cycle n carry the colour of the coordinate issued LAT cycles before.
    task automatic drive(input int n);
        int ht, vt, k, x, y;
        logic [11:0] c;
        for (int i = 0; i < NI; i++) begin
            ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
            vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
            k  = n - P_LAT[i];
            if (k >= 0) begin
                x = k % ht;
                y = (k / ht) % vt;
                c = col_of(i, x, y);
                ir[i]  = c[11:8];
                ig[i]  = c[7:4];
                ib[i]  = c[3:0];
                blk[i] = blank_of(i, x, y);
            end else begin
                ir[i]  = 4'h0;
                ig[i]  = 4'h0;
                ib[i]  = 4'h0;
                blk[i] = 1'b0;
            end
        end
    endtask

    task automatic run(input int ncyc, input bit first);
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("track_i%0d_n%0d", i, n), 64'(obs(i)), 64'(model(i, n)));
            end
            if (first) begin
                if (n >= 800 && n < 1600) begin
                    if (hs_w[0] == 1'b0) def_hs++;
                    if (de_w[0] == 1'b1) def_de++;
                end
                if (n < 1280 && fs_w[4] == 1'b1) sm_fs++;
                if (n >= 200 && n < 328) begin
                    if (hs_w[4] == 1'b1) sm_hh++;
                    if (vs_w[4] == 1'b0) sm_vl++;
                end
                if (n == 2) begin
                    chk("sm_red_w1", 64'(r_w[4]), 64'hF);
                    chk("sm_green_w2", 64'(g_w[4]), 64'hA);
                    chk("sm_blue_w4", 64'(b_w[4]), 64'h6);
                end
                if (n == 7) begin
                    chk("lat0_red_x6", 64'(r_w[1]), 64'hD);
                    chk("lat2_red_x4", 64'(r_w[2]), 64'h9);
                end
                if (n == 10) chk("lat4_red_x5", 64'(r_w[3]), 64'hB);
                if (n == 11) begin
                    chk("def_red_x9", 64'(r_w[0]), 64'hF);
                    chk("def_blue_x9", 64'(b_w[0]), 64'hF);
                end
                if (n == 12) begin
                    chk("def_blank_red_x10", 64'(r_w[0]), 64'h0);
                    chk("def_blank_de_x10", 64'(de_w[0]), 64'h1);
                end
                if (n == 15) chk("sm_hc_15", 64'(hc_w[4]), 64'd15);
                if (n == 16) begin
                    chk("sm_hc_wrap", 64'(hc_w[4]), 64'd0);
                    chk("sm_vc_step", 64'(vc_w[4]), 64'd1);
                end
                if (n == 127) chk("sm_vc_7", 64'(vc_w[4]), 64'd7);
                if (n == 128) begin
                    chk("sm_vc_wrap", 64'(vc_w[4]), 64'd0);
                    chk("sm_fs_128", 64'(fs_w[4]), 64'd1);
                end
            end else if (n == 0) begin
                chk("rel_line_start", 64'(ls_w[0]), 64'd1);
                chk("rel_frame_start", 64'(fs_w[0]), 64'd1);
                chk("rel_hc", 64'(hc_w[0]), 64'd0);
            end
            drive(n);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        drive(-1);
        #5 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("reset_i%0d", i), 64'(obs(i)), 64'(model(i, 0)));
        @(posedge clk);
        #1 rst_n = 1'b1;

        run(2301, 1'b1);
        chk("def_hsync_low_per_line", 64'(def_hs), 64'd96);
        chk("def_de_per_line", 64'(def_de), 64'd640);
        chk("sm_frame_starts_1280", 64'(sm_fs), 64'd10);
        chk("sm_hsync_high_128", 64'(sm_hh), 64'd24);
        chk("sm_vsync_low_128", 64'(sm_vl), 64'd32);

        // u_def now sits at hc=700, vc=2, inside a sync pulse.
        chk("def_hc_before_rst", 64'(hc_w[0]), 64'd700);
        chk("def_hsync_before_rst", 64'(hs_w[0]), 64'd0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("rst_mid_i%0d", i), 64'(obs(i)), 64'(model(i, 0)));
        chk("def_hsync_after_rst", 64'(hs_w[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(300, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
